// File: rtl/video_pattern_gen_if.sv
// Pixel stream bundle carried from the pattern source to a sink such as hdmi_tx.
// The master drives the stream; the slave observes it.
interface video_pattern_gen_if;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_start;

    modport master (
        output rgb_out,
        output de_out,
        output hsync_out,
        output vsync_out,
        output frame_start
    );

    modport slave (
        input rgb_out,
        input de_out,
        input hsync_out,
        input vsync_out,
        input frame_start
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Timing-compliant RGB/DE/sync source with built-in test patterns.
// Every output is registered one cycle behind the h/v counter state.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    video_pattern_gen_if.master        vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int B_W     = $clog2(BAR_W + 1);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [B_W-1:0] BAR_LAST = B_W'(BAR_W - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic [B_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic [23:0]    rgb_q, rgb_d;
    logic           de_q, de_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           fs_q, fs_d;

    logic           run;
    logic [1:0]     cur_sel;
    logic           h_last;
    logic           v_last;
    logic [7:0]     x_lo;
    logic [7:0]     y_lo;
    logic [23:0]    pix;

    // While idle the live inputs stand in for the latched ones, so a frame starts on the enabling cycle.
    assign run     = (state_q == ST_RUN) || enable;
    assign cur_sel = (state_q == ST_RUN) ? sel_q : pattern_sel;
    assign h_last  = (h_cnt_q == H_LAST);
    assign v_last  = (v_cnt_q == V_LAST);
    assign x_lo    = 8'(h_cnt_q);
    assign y_lo    = 8'(v_cnt_q);

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'h00FFFF;
            3'd2:    c = 24'hFFFF00;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'h0000FF;
            3'd6:    c = 24'hFF0000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    always_comb begin
        pix = '0;
        case (cur_sel)
            2'd0:    pix = bar_colour(bar_idx_q);
            2'd1:    pix = {x_lo, x_lo, x_lo};
            2'd2:    pix = (x_lo[5] ^ y_lo[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix = {frame_cnt_q, y_lo, x_lo + frame_cnt_q};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        rgb_d       = '0;
        de_d        = 1'b0;
        hs_d        = ~HS_POL;
        vs_d        = ~VS_POL;
        fs_d        = 1'b0;

        if (run) begin
            de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            rgb_d   = de_d ? pix : '0;
            hs_d    = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
            vs_d    = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
            fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
            state_d = ST_RUN;
            if (state_q == ST_IDLE) begin
                sel_d = pattern_sel;
            end

            if (h_last) begin
                h_cnt_d   = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                v_cnt_d   = v_last ? '0 : v_cnt_q + 1'b1;
                if (v_last) begin
                    state_d     = enable ? ST_RUN : ST_IDLE;
                    sel_d       = pattern_sel;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                // Bar index advances once per BAR_W pixels and sticks at 7 for any remainder.
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    if (bar_idx_q != 3'd7) begin
                        bar_idx_d = bar_idx_q + 3'd1;
                    end
                end else begin
                    bar_cnt_d = bar_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            rgb_q       <= rgb_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
        end
    end

    assign vid.rgb_out     = rgb_q;
    assign vid.de_out      = de_q;
    assign vid.hsync_out   = hs_q;
    assign vid.vsync_out   = vs_q;
    assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a small 24x8 raster: a behavioural model fills a
// scoreboard as inputs are driven, and each scenario task also checks its own spec values.
module tb_video_pattern_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;

    video_pattern_gen_if vid ();

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .vid        (vid)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [27:0] sb[$];

    int         m_h = 0, m_v = 0, m_fc = 0;
    int         last_h = -1, last_v = -1;
    bit         m_run = 1'b0;
    logic [1:0] m_sel = 2'd0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                 24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    function automatic logic [27:0] obs();
        return {vid.rgb_out, vid.de_out, vid.hsync_out, vid.vsync_out, vid.frame_start};
    endfunction

    function automatic logic [23:0] ref_pixel(int x, int y, logic [1:0] sel, int fc);
        logic [23:0] c;
        int          idx;
        c = 24'h0;
        case (sel)
            2'd0: begin
                idx = x / (HA / 8);
                if (idx > 7) idx = 7;
                c = bar_tab[idx];
            end
            2'd1: c = {8'(x), 8'(x), 8'(x)};
            2'd2: c = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            default: c = {8'(fc), 8'(y), 8'(x + fc)};
        endcase
        return c;
    endfunction

    // Predict the outputs after the coming edge from the inputs now on the pins.
    task automatic model_step();
        logic [27:0] e;
        bit          run;
        bit          de;
        logic [1:0]  s;
        e = '0;
        last_h = -1;
        last_v = -1;
        if (rst) begin
            m_h = 0; m_v = 0; m_fc = 0; m_run = 1'b0; m_sel = 2'd0;
        end else begin
            run = m_run || enable;
            s   = m_run ? m_sel : pattern_sel;
            if (run) begin
                de       = (m_h < HA) && (m_v < VA);
                e[27:4]  = de ? ref_pixel(m_h, m_v, s, m_fc) : 24'h0;
                e[3]     = de;
                e[2]     = (m_h >= HA + HF) && (m_h < HA + HF + HS);
                e[1]     = (m_v >= VA + VF) && (m_v < VA + VF + VS);
                e[0]     = (m_h == 0) && (m_v == 0);
                last_h   = m_h;
                last_v   = m_v;
                if (!m_run) begin
                    m_run = 1'b1;
                    m_sel = pattern_sel;
                end
                if (m_h == HT - 1 && m_v == VT - 1) begin
                    m_run = enable;
                    m_sel = pattern_sel;
                    m_fc  = (m_fc + 1) % 256;
                end
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic tick(input logic en, input logic [1:0] sel, input logic r);
        rst         = r;
        enable      = en;
        pattern_sel = sel;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [27:0] got, exp;
        repeat (4) begin
            tick(1'b1, 2'd1, 1'b1);
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_reset got=%h exp=%h", got, exp); end
            vectors++;
            if (got !== 28'h0) begin miscompares++; $display("[TB] FAIL reset_idle got=%h exp=%h", got, 28'h0); end
        end
    endtask

    task automatic test_run();
        logic [27:0] got, exp;
        int  since_fs = -1;
        int  de_run = 0;
        int  de_lines = 0;
        bit  prev_vs = 1'b0;
        for (int c = 0; c < 3 * FRAME + 10; c++) begin
            tick(1'b1, 2'd0, 1'b0);
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_run got=%h exp=%h", got, exp); end
            if (c == 0) begin
                vectors++;
                if (got[0] !== 1'b1 || got[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL first_pixel fs/de=%b%b exp=11", got[0], got[3]); end
            end
            if (got[3]) de_run++;
            else if (de_run != 0) begin
                vectors++;
                if (de_run != HA) begin miscompares++; $display("[TB] FAIL de_len got=%0d exp=%0d", de_run, HA); end
                de_lines++;
                de_run = 0;
            end
            if (since_fs >= 0) since_fs++;
            if (got[0]) begin
                if (since_fs > 0) begin
                    vectors++;
                    if (since_fs != 192) begin miscompares++; $display("[TB] FAIL fs_period got=%0d exp=192", since_fs); end
                    vectors++;
                    if (de_lines != 4) begin miscompares++; $display("[TB] FAIL de_lines got=%0d exp=4", de_lines); end
                end
                since_fs = 0;
                de_lines = 0;
            end
            vectors++;
            if (got[2] !== (last_h >= 18 && last_h <= 20)) begin miscompares++; $display("[TB] FAIL hsync_pos h=%0d got=%b", last_h, got[2]); end
            vectors++;
            if (got[1] !== (last_v >= 5 && last_v <= 6)) begin miscompares++; $display("[TB] FAIL vsync_pos v=%0d got=%b", last_v, got[1]); end
            if (got[1] !== prev_vs) begin
                vectors++;
                if (last_h != 0) begin miscompares++; $display("[TB] FAIL vsync_edge h=%0d exp=0", last_h); end
            end
            prev_vs = got[1];
        end
    endtask

    task automatic test_bars();
        logic [27:0] got, exp;
        int line0 = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick(1'b1, 2'd0, 1'b0);
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_bars got=%h exp=%h", got, exp); end
            if (got[3]) begin
                vectors++;
                if (got[27:4] !== bar_tab[last_h / 2]) begin miscompares++; $display("[TB] FAIL bar_rgb x=%0d y=%0d got=%h exp=%h", last_h, last_v, got[27:4], bar_tab[last_h / 2]); end
                if (last_v == 0) line0++;
            end
        end
        vectors++;
        if (line0 != 2 * HA) begin miscompares++; $display("[TB] FAIL bar_line0_count got=%0d exp=%0d", line0, 2 * HA); end
    endtask

    task automatic test_switch();
        logic [27:0] got, exp;
        int fr = 0, cyc = 0, black = 0, guard = 0;
        logic [1:0] sel;
        while (fr < 3 && guard < 4 * FRAME) begin
            sel = (fr >= 1 && cyc >= 50) ? 2'd2 : 2'd0;
            tick(1'b1, sel, 1'b0);
            guard++; cyc++;
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_switch got=%h exp=%h", got, exp); end
            if (got[0]) begin fr++; cyc = 0; end
            if (got[3] && fr == 1) begin
                vectors++;
                if (got[27:4] !== bar_tab[last_h / 2]) begin miscompares++; $display("[TB] FAIL switch_old_frame x=%0d got=%h exp=%h", last_h, got[27:4], bar_tab[last_h / 2]); end
            end
            if (got[3] && fr == 2) begin
                black++;
                vectors++;
                if (got[27:4] !== 24'h000000) begin miscompares++; $display("[TB] FAIL checker_black x=%0d y=%0d got=%h exp=000000", last_h, last_v, got[27:4]); end
            end
        end
        vectors++;
        if (fr < 3 || black != HA * VA) begin miscompares++; $display("[TB] FAIL switch_frames frames=%0d black=%0d exp=3/%0d", fr, black, HA * VA); end
    endtask

    task automatic test_enable();
        logic [27:0] got, exp;
        int stage = 0, cnt = 0, de_cnt = 0, idle_n = 0, guard = 0;
        logic en;
        while (stage < 4 && guard < 4 * FRAME) begin
            en = (stage == 0) || (stage == 1 && cnt < 60) || (stage == 3);
            tick(en, 2'd0, 1'b0);
            guard++;
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_enable got=%h exp=%h", got, exp); end
            case (stage)
                0: if (got[0]) begin stage = 1; cnt = 0; de_cnt = 1; end
                1: begin
                    cnt++;
                    if (got[3]) de_cnt++;
                    if (cnt == FRAME - 1) begin
                        vectors++;
                        if (de_cnt != HA * VA) begin miscompares++; $display("[TB] FAIL enable_frame_done de=%0d exp=%0d", de_cnt, HA * VA); end
                        stage = 2;
                    end
                end
                2: begin
                    vectors++;
                    if (got !== 28'h0) begin miscompares++; $display("[TB] FAIL idle_out got=%h exp=%h", got, 28'h0); end
                    idle_n++;
                    if (idle_n == 20) stage = 3;
                end
                default: begin
                    vectors++;
                    if (got[0] !== 1'b1 || got[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL fs_on_enable fs/de=%b%b exp=11", got[0], got[3]); end
                    stage = 4;
                end
            endcase
        end
        vectors++;
        if (stage != 4) begin miscompares++; $display("[TB] FAIL enable_timeout stage=%0d exp=4", stage); end
    endtask

    task automatic test_scroll();
        logic [27:0] got, exp;
        int fr = 0, guard = 0, prev_b = -1;
        bit wrap_seen = 1'b0;
        while (fr < 263 && guard < 265 * FRAME) begin
            tick(1'b1, 2'd3, 1'b0);
            guard++;
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_scroll got=%h exp=%h", got, exp); end
            if (got[0]) fr++;
            if (fr >= 2 && last_h == 3 && last_v == 0) begin
                vectors++;
                if (got[11:4] !== 8'(3 + m_fc) || got[27:20] !== 8'(m_fc) || got[19:12] !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL scroll_px fc=%0d got=%h exp_r=%h exp_b=%h", m_fc, got[27:4], 8'(3 + m_fc), 8'(m_fc));
                end
                if (prev_b == 255) begin
                    wrap_seen = 1'b1;
                    vectors++;
                    if (got[27:20] !== 8'h00 || got[11:4] !== 8'h03) begin miscompares++; $display("[TB] FAIL scroll_wrap got=%h exp_r=03 exp_b=00", got[27:4]); end
                end
                prev_b = int'(got[27:20]);
            end
        end
        vectors++;
        if (!wrap_seen) begin miscompares++; $display("[TB] FAIL scroll_wrap_seen got=0 exp=1"); end
    endtask

    task automatic test_reset_mid();
        logic [27:0] got, exp;
        int stage = 0, guard = 0;
        logic r;
        while (stage < 2 && guard < 2 * FRAME) begin
            r = (stage == 0) && (m_h == 7) && (m_v == 2);
            tick(1'b1, 2'd0, r);
            guard++;
            got = obs(); exp = sb.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("[TB] FAIL sb_rst_mid got=%h exp=%h", got, exp); end
            if (stage == 1) begin
                vectors++;
                if (got[0] !== 1'b1 || got[3] !== 1'b1 || got[27:4] !== 24'hFFFFFF) begin miscompares++; $display("[TB] FAIL fs_after_rst got=%h exp=%h", got, {24'hFFFFFF, 4'b1001}); end
                stage = 2;
            end
            if (r) begin
                vectors++;
                if (got !== 28'h0) begin miscompares++; $display("[TB] FAIL rst_mid_idle got=%h exp=%h", got, 28'h0); end
                stage = 1;
            end
        end
        vectors++;
        if (stage != 2) begin miscompares++; $display("[TB] FAIL rst_mid_timeout stage=%0d exp=2", stage); end
    endtask

    initial begin
        @(negedge clk);
        $display("[TB] starting video_pattern_gen scenarios");
        test_reset();
        test_run();
        test_bars();
        test_switch();
        test_enable();
        test_scroll();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
